// File: rtl/mmio_io_bank.sv
// mmio_io_bank
// Memory-mapped I/O bank that sits beside the data memory. It provides
// N_OUT writable output registers and N_IN synchronised input channels.
// Each input channel has a sticky change flag. A maskable level interrupt
// is raised from those flags.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   addr     - byte address (ULA result)
//   wdata    - store data
//   we       - store strobe
//   rdata    - combinational read data (0 outside the window)
//   hit      - addr lies inside the register window
//   in_data  - asynchronous inputs, channel i at [i*DW +: DW]
//   out_data - output registers, register k at [k*DW +: DW]
//   irq      - |(FLAGS & MASK)
//
// Register map (offset = addr - BASE):
//   0 .. N_OUT-1             OUT[k]  read/write
//   N_OUT .. N_OUT+N_IN-1    IN[i]   read-only, synchronised value
//   N_OUT+N_IN               FLAGS   change flags, write-1-to-clear
//   N_OUT+N_IN+1             MASK    interrupt mask
module mmio_io_bank #(
   parameter int unsigned    DW      = 8,
   parameter int unsigned    AW      = 8,
   parameter int unsigned    N_OUT   = 2,
   parameter int unsigned    N_IN    = 2,
   parameter logic [AW-1:0]  BASE    = 8'hF0,
   parameter logic [DW-1:0]  OUT_RST = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AW-1:0]         addr,
   input  logic [DW-1:0]         wdata,
   input  logic                  we,
   output logic [DW-1:0]         rdata,
   output logic                  hit,
   input  logic [N_IN*DW-1:0]    in_data,
   output logic [N_OUT*DW-1:0]   out_data,
   output logic                  irq
);

   localparam logic [AW-1:0] FLAGS_OFF = AW'(N_OUT + N_IN);
   localparam logic [AW-1:0] MASK_OFF  = AW'(N_OUT + N_IN + 1);

   logic [DW-1:0]   out_reg [N_OUT];
   logic [DW-1:0]   sync1   [N_IN];
   logic [DW-1:0]   sync2   [N_IN];
   logic [DW-1:0]   sync3   [N_IN];
   logic [N_IN-1:0] flags;
   logic [N_IN-1:0] mask;
   logic [1:0]      warm_cnt;

   logic [AW-1:0]   off;
   logic            wr_en;
   logic            warm;
   logic [N_IN-1:0] set;
   logic [N_IN-1:0] clr;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   assign off   = addr - BASE;
   assign hit   = (addr >= BASE) && (off <= MASK_OFF);
   assign wr_en = we && hit;

   // Flag setting is enabled only once the registered counter holds 3.
   // The chain's reset-to-0 state produces one spurious s2/s3 difference
   // that is consumed on the third edge after release, so it never reaches
   // FLAGS.
   assign warm = (warm_cnt == 2'd3);

   always_comb begin
      set = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         set[i] = warm && (sync2[i] != sync3[i]);
      end
   end

   assign clr = (wr_en && (off == FLAGS_OFF)) ? wdata[N_IN-1:0] : '0;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_OUT; k++) begin
            out_reg[k] <= OUT_RST;
         end
         for (int unsigned i = 0; i < N_IN; i++) begin
            sync1[i] <= '0;
            sync2[i] <= '0;
            sync3[i] <= '0;
         end
         flags    <= '0;
         mask     <= '0;
         warm_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < N_OUT; k++) begin
            if (wr_en && (off == AW'(k))) begin
               out_reg[k] <= wdata;
            end
         end
         for (int unsigned i = 0; i < N_IN; i++) begin
            sync1[i] <= in_data[i*DW +: DW];
            sync2[i] <= sync1[i];
            sync3[i] <= sync2[i];
         end
         // Set wins over a same-edge clear.
         flags <= (flags & ~clr) | set;
         if (wr_en && (off == MASK_OFF)) begin
            mask <= wdata[N_IN-1:0];
         end
         if (warm_cnt != 2'd3) begin
            warm_cnt <= warm_cnt + 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read mux and outputs
   // ------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (hit) begin
         for (int unsigned k = 0; k < N_OUT; k++) begin
            if (off == AW'(k)) begin
               rdata = out_reg[k];
            end
         end
         for (int unsigned i = 0; i < N_IN; i++) begin
            if (off == AW'(N_OUT + i)) begin
               rdata = sync2[i];
            end
         end
         if (off == FLAGS_OFF) begin
            rdata = DW'(flags);
         end
         if (off == MASK_OFF) begin
            rdata = DW'(mask);
         end
      end
   end

   always_comb begin
      out_data = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         out_data[k*DW +: DW] = out_reg[k];
      end
   end

   assign irq = |(flags & mask);

endmodule

// File: tb/tb_mmio_io_bank.sv
// Directed testbench for mmio_io_bank with the default parameters
// (DW=8, AW=8, N_OUT=2, N_IN=2, BASE=8'hF0, OUT_RST=0).
// Map: F0/F1 OUT0/OUT1, F2/F3 IN0/IN1, F4 FLAGS, F5 MASK.
module tb_mmio_io_bank;

   logic        clk;
   logic        rst;
   logic [7:0]  addr;
   logic [7:0]  wdata;
   logic        we;
   logic [7:0]  rdata;
   logic        hit;
   logic [15:0] in_data;
   logic [15:0] out_data;
   logic        irq;

   int tests;
   int fails;

   mmio_io_bank #(
      .DW      (8),
      .AW      (8),
      .N_OUT   (2),
      .N_IN    (2),
      .BASE    (8'hF0),
      .OUT_RST (8'h00)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .rdata    (rdata),
      .hit      (hit),
      .in_data  (in_data),
      .out_data (out_data),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      rst     = 1'b0;
      we      = 1'b0;
      addr    = 8'h00;
      wdata   = 8'h00;
      in_data = 16'h005A;

      // Reset state
      #12;
      check("rst_out", out_data, 16'h0000);
      check("rst_irq", irq, 0);
      rd("rst_flags", 8'hF4, 8'h00);
      rst = 1'b1;

      // Warm-up: no spurious flags, IN0 visible after two edges
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c == 1) rd("in0_after2", 8'hF2, 8'h5A);
         rd("warm_flags", 8'hF4, 8'h00);
         check("warm_irq", irq, 0);
      end

      // Output write
      wr(8'hF1, 8'hC3);
      check("out1_wr", out_data, 16'hC300);
      rd("out1_rd", 8'hF1, 8'hC3);
      check("out1_hit", hit, 1);

      // Out-of-window writes
      wr(8'hEF, 8'hFF);
      check("oow_out", out_data, 16'hC300);
      check("oow_hit", hit, 0);
      rd("oow_rdata", 8'hEF, 8'h00);
      wr(8'hF6, 8'hFF);
      check("past_hit", hit, 0);
      rd("past_rdata", 8'hF6, 8'h00);
      rd("past_mask", 8'hF5, 8'h00);

      // Mask ch1 then change ch1 00 -> 01
      wr(8'hF5, 8'h02);
      rd("mask_rd", 8'hF5, 8'h02);
      in_data = 16'h015A;
      tick();                                  // edge k
      rd("in1_k", 8'hF3, 8'h00);
      tick();                                  // edge k+1
      rd("in1_k1", 8'hF3, 8'h01);
      rd("flag_k1", 8'hF4, 8'h00);
      check("irq_k1", irq, 0);
      tick();                                  // edge k+2
      rd("flag_k2", 8'hF4, 8'h02);
      check("irq_k2", irq, 1);

      // W1C
      wr(8'hF4, 8'h02);
      rd("w1c_flag", 8'hF4, 8'h00);
      check("w1c_irq", irq, 0);

      // Clear collides with a new ch1 event: set wins
      in_data = 16'h005A;
      tick();                                  // edge k
      tick();                                  // edge k+1
      wr(8'hF4, 8'h02);                        // edge k+2
      rd("coll_flag", 8'hF4, 8'h02);
      check("coll_irq", irq, 1);
      wr(8'hF4, 8'h02);
      rd("coll_clr", 8'hF4, 8'h00);

      // Mask behaviour
      wr(8'hF5, 8'h00);
      in_data = 16'hFFA5;
      tick();
      tick();
      tick();
      rd("both_flags", 8'hF4, 8'h03);
      check("masked_irq", irq, 0);
      wr(8'hF5, 8'hFF);
      check("unmask_irq", irq, 1);
      rd("mask_trunc", 8'hF5, 8'h03);

      // Write to IN is ignored
      wr(8'hF2, 8'h11);
      rd("in0_ro", 8'hF2, 8'hA5);
      check("in_wr_out", out_data, 16'hC300);
      wr(8'hF4, 8'hFF);
      rd("clr_all", 8'hF4, 8'h00);
      check("clr_irq", irq, 0);

      // Asynchronous reset mid-operation
      wr(8'hF0, 8'h77);
      check("out0_wr", out_data, 16'hC377);
      #2;
      rst = 1'b0;
      #1;
      check("async_out", out_data, 16'h0000);
      addr  = 8'hF0;
      wdata = 8'h55;
      we    = 1'b1;
      tick();
      we    = 1'b0;
      check("rst_wr_out", out_data, 16'h0000);
      rd("rst_mask", 8'hF5, 8'h00);
      rst = 1'b1;
      tick();
      check("post_rst_out", out_data, 16'h0000);
      check("post_rst_irq", irq, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
